// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit.
// Accepts one memory instruction from execute and stalls the core while the
// access is outstanding. Drives a word-wide, byte-enabled data bus with a
// variable-latency ack and returns the aligned, extended load result.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   lsu_req_i/we_i/size_i  memory instruction from decode/execute (funct3 size)
//   lsu_addr_i/data_i      byte address, store data (rs2)
//   lsu_data_o             load result, updated on each completed load
//   lsu_stall_req_o        combinational pipeline hold
//   lsu_fault_o/cause_o    one-cycle fault pulse; 01 misaligned, 10 bad size,
//                          11 bus timeout
//   data_*                 data-memory bus (word address, byte enables, ack)
module riscv_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_fault_o,
    output logic [1:0]  lsu_fault_cause_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    input  logic        data_ack_i
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    size_q, size_d;
    logic [1:0]    off_q, off_d;

    logic          req_d, we_d, fault_d;
    logic [3:0]    be_d;
    logic [31:0]   addr_d, wdata_d, ld_d;
    logic [1:0]    cause_d;

    // Request decode
    logic [1:0]  off;
    logic        bad_size, misalign, legal;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;

    assign off = lsu_addr_i[1:0];

    // Sizes 3,6,7 do not exist; unsigned variants only make sense for loads.
    assign bad_size = (lsu_size_i == 3'd3) || (lsu_size_i[2:1] == 2'b11) ||
                      (lsu_we_i && lsu_size_i[2]);
    assign misalign = ((lsu_size_i[1:0] == 2'b01) && lsu_addr_i[0]) ||
                      ((lsu_size_i[1:0] == 2'b10) && (off != 2'b00));
    assign legal    = !bad_size && !misalign;

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = lsu_data_i;
        case (lsu_size_i[1:0])
            2'b00: begin
                be_new    = 4'b0001 << off;
                wdata_new = {4{lsu_data_i[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << off;
                wdata_new = {2{lsu_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extraction from the lane captured at request time
    logic [31:0] rd_shift, ld_ext;

    assign rd_shift = data_rdata_i >> {off_q, 3'b000};

    always_comb begin
        ld_ext = data_rdata_i;
        case (size_q)
            3'd0: ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'd1: ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'd4: ld_ext = {24'd0, rd_shift[7:0]};
            3'd5: ld_ext = {16'd0, rd_shift[15:0]};
            default: ;
        endcase
    end

    // Next-state / next-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        off_d   = off_q;
        req_d   = data_req_o;
        we_d    = data_we_o;
        be_d    = data_be_o;
        addr_d  = data_addr_o;
        wdata_d = data_wdata_o;
        ld_d    = lsu_data_o;
        fault_d = 1'b0;
        cause_d = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (lsu_req_i) begin
                    if (legal) begin
                        req_d   = 1'b1;
                        we_d    = lsu_we_i;
                        be_d    = be_new;
                        addr_d  = {lsu_addr_i[31:2], 2'b00};
                        wdata_d = wdata_new;
                        size_d  = lsu_size_i;
                        off_d   = off;
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end else begin
                        fault_d = 1'b1;
                        cause_d = bad_size ? 2'b10 : 2'b01;
                    end
                end
            end
            S_WAIT: begin
                // Ack beats a timeout landing in the same cycle.
                if (data_ack_i) begin
                    req_d   = 1'b0;
                    if (!data_we_o) ld_d = ld_ext;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    cause_d = 2'b11;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                // lsu_req_i still belongs to the instruction just completed.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q           <= S_IDLE;
            cnt_q             <= '0;
            size_q            <= 3'd0;
            off_q             <= 2'd0;
            data_req_o        <= 1'b0;
            data_we_o         <= 1'b0;
            data_be_o         <= 4'd0;
            data_addr_o       <= 32'd0;
            data_wdata_o      <= 32'd0;
            lsu_data_o        <= 32'd0;
            lsu_fault_o       <= 1'b0;
            lsu_fault_cause_o <= 2'b00;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            size_q            <= size_d;
            off_q             <= off_d;
            data_req_o        <= req_d;
            data_we_o         <= we_d;
            data_be_o         <= be_d;
            data_addr_o       <= addr_d;
            data_wdata_o      <= wdata_d;
            lsu_data_o        <= ld_d;
            lsu_fault_o       <= fault_d;
            lsu_fault_cause_o <= cause_d;
        end
    end

    assign lsu_stall_req_o = (state_q == S_WAIT) ||
                             ((state_q == S_IDLE) && lsu_req_i && legal);

endmodule

// File: tb/tb_riscv_lsu.sv
module tb_riscv_lsu;

    localparam int TMO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        lsu_req_i, lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i, lsu_data_i;
    logic [31:0] lsu_data_o;
    logic        lsu_stall_req_o, lsu_fault_o;
    logic [1:0]  lsu_fault_cause_o;
    logic        data_req_o, data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
    logic        data_ack_i;

    riscv_lsu #(.TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
        .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
        .lsu_data_o(lsu_data_o), .lsu_stall_req_o(lsu_stall_req_o),
        .lsu_fault_o(lsu_fault_o), .lsu_fault_cause_o(lsu_fault_cause_o),
        .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_rdata_i(data_rdata_i), .data_ack_i(data_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic        fault;
        logic [1:0]  cause;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic        prev_req = 1'b0;
    logic [31:0] ld_model = 32'd0;

    // Reference model
    function automatic logic [1:0] m_cause(input logic we, input logic [2:0] sz, input logic [31:0] a);
        if (sz == 3 || sz == 6 || sz == 7 || (we && (sz == 4 || sz == 5))) return 2'b10;
        if ((sz == 1 || sz == 5) && a[0]) return 2'b01;
        if (sz == 2 && a[1:0] != 2'b00) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] sz, input logic [1:0] off);
        case (sz)
            3'd0, 3'd4: case (off) 0: return 4'b0001; 1: return 4'b0010; 2: return 4'b0100; default: return 4'b1000; endcase
            3'd1, 3'd5: return off[1] ? 4'b1100 : 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] sz, input logic [31:0] d);
        case (sz)
            3'd0:    return {d[7:0], d[7:0], d[7:0], d[7:0]};
            3'd1:    return {d[15:0], d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] sz, input logic [1:0] off, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            0: b = rd[7:0];
            1: b = rd[15:8];
            2: b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = off[1] ? rd[31:16] : rd[15:0];
        case (sz)
            3'd0:    return b[7] ? {24'hFFFFFF, b} : {24'h0, b};
            3'd4:    return {24'h0, b};
            3'd1:    return h[15] ? {16'hFFFF, h} : {16'h0, h};
            3'd5:    return {16'h0, h};
            default: return rd;
        endcase
    endfunction

    // Completion monitor: a DONE cycle (bus request just dropped) or an
    // IDLE fault pulse pops one scoreboard entry.
    always @(negedge clk_i) begin
        if (rst_i) begin
            prev_req = 1'b0;
        end else begin
            if ((prev_req && !data_req_o) || (!prev_req && lsu_fault_o)) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("fault", lsu_fault_o, mon_e.fault);
                    chk("cause", lsu_fault_cause_o, mon_e.cause);
                    chk("ld_data", lsu_data_o, mon_e.data);
                end
            end
            prev_req = data_req_o;
        end
    end

    // ack_at: WAIT cycle (1-based) on which ack is driven; 0 = never ack.
    task automatic mem_op(input logic we, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int ack_at);
        logic [1:0] c;
        int req_cyc, stall_cyc, nreq;
        c = m_cause(we, sz, a);
        @(posedge clk_i); #1;
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = sz;
        lsu_addr_i = a; lsu_data_i = wd; data_rdata_i = rd;
        if (c != 2'b00) begin
            sb.push_back('{1'b1, c, ld_model});
            #1 chk("stall_on_fault", lsu_stall_req_o, 0);
            @(posedge clk_i); #1;
            lsu_req_i = 1'b0;
            chk("no_bus_req", data_req_o, 0);
            @(posedge clk_i); #1;
            chk("fault_one_cycle", lsu_fault_o, 0);
            return;
        end
        nreq = (ack_at != 0) ? ack_at : TMO;
        if (!we && ack_at != 0) ld_model = m_load(sz, a[1:0], rd);
        sb.push_back('{ack_at == 0, (ack_at == 0) ? 2'b11 : 2'b00, ld_model});
        #1 stall_cyc = int'(lsu_stall_req_o);
        req_cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk_i); #1;
            data_ack_i = 1'b0;
            if (i == 1) begin
                chk("req_issued", data_req_o, 1);
                chk("bus_we", data_we_o, we);
                chk("bus_addr", data_addr_o, {a[31:2], 2'b00});
                chk("bus_be", data_be_o, m_be(sz, a[1:0]));
                if (we) chk("bus_wdata", data_wdata_o, m_wdata(sz, wd));
            end
            if (!data_req_o) break;
            req_cyc++;
            stall_cyc += int'(lsu_stall_req_o);
            if (i == ack_at) data_ack_i = 1'b1;
        end
        chk("req_cycles", req_cyc, nreq);
        chk("stall_cycles", stall_cyc, nreq + 1);
        chk("done_stall", lsu_stall_req_o, 0);
        @(posedge clk_i); #1;
        lsu_req_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 3'd0;
        lsu_addr_i = 32'd0; lsu_data_i = 32'd0; data_rdata_i = 32'd0; data_ack_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_req", data_req_o, 0);
        chk("rst_fault", lsu_fault_o, 0);
        chk("rst_data", lsu_data_o, 0);
        chk("rst_be", data_be_o, 0);
        chk("rst_addr", data_addr_o, 0);
        chk("rst_stall", lsu_stall_req_o, 0);
        rst_i = 1'b0;

        mem_op(0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 3);  // LW
        mem_op(0, 3'd0, 32'h203, 0, 32'h80112233, 2);  // LB  -> FFFFFF80
        mem_op(0, 3'd4, 32'h203, 0, 32'h80112233, 1);  // LBU -> 00000080
        mem_op(1, 3'd1, 32'h302, 32'h0000ABCD, 0, 1);  // SH
        mem_op(0, 3'd1, 32'h102, 0, 32'h8001_7FFF, 2); // LH  -> FFFF8001
        mem_op(0, 3'd5, 32'h102, 0, 32'h8001_7FFF, 1); // LHU -> 00008001
        mem_op(0, 3'd0, 32'h041, 0, 32'h0000_F500, 1); // LB off 1 -> FFFFFFF5
        mem_op(1, 3'd0, 32'h501, 32'h123456A5, 0, 2);  // SB
        mem_op(1, 3'd2, 32'h600, 32'hCAFEF00D, 0, 3);  // SW
        mem_op(0, 3'd2, 32'h101, 0, 0, 1);             // misaligned W
        mem_op(0, 3'd5, 32'h103, 0, 0, 1);             // misaligned HU
        mem_op(1, 3'd4, 32'h100, 32'h1, 0, 1);         // store size 4
        mem_op(0, 3'd3, 32'h100, 0, 0, 1);             // size 3
        mem_op(1, 3'd5, 32'h101, 0, 0, 1);             // bad size beats misaligned
        mem_op(0, 3'd2, 32'h700, 0, 32'h11111111, 0);  // timeout
        mem_op(0, 3'd2, 32'h704, 0, 32'h22222222, TMO);// ack on last cycle

        // Ack while idle must not disturb anything
        @(posedge clk_i); #1;
        data_ack_i = 1'b1; data_rdata_i = 32'h12345678;
        @(posedge clk_i); #1;
        data_ack_i = 1'b0;
        chk("idle_ack_req", data_req_o, 0);
        chk("idle_ack_data", lsu_data_o, ld_model);

        // Reset during the second WAIT cycle
        @(posedge clk_i); #1;
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2; lsu_addr_i = 32'h400;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1'b1; lsu_req_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("mid_rst_req", data_req_o, 0);
        chk("mid_rst_stall", lsu_stall_req_o, 0);
        chk("mid_rst_fault", lsu_fault_o, 0);
        chk("mid_rst_be", data_be_o, 0);
        chk("mid_rst_data", lsu_data_o, 0);
        ld_model = 32'd0;
        mem_op(0, 3'd2, 32'h104, 0, 32'h0BADF00D, 2);

        repeat (3) @(posedge clk_i);
        chk("sb_leftover", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit; the responder for the decoder's memory-control outputs (mem_req, mem_we, mem_size).
- Takes one memory instruction from the execute stage and stalls the core while the access is outstanding.
- Drives a word-wide, byte-enabled data-memory bus with a variable-latency ack.
- Returns the aligned, sign- or zero-extended load result.

Parameters:
TIMEOUT, 16, max cycles data_req_o may stay high without data_ack_i before a bus fault (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
lsu_req_i  in  1  memory instruction present (decoder mem_req)
lsu_we_i  in  1  1=store, 0=load (decoder mem_we)
lsu_size_i  in  3  funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU
lsu_addr_i  in  32  byte address from ALU
lsu_data_i  in  32  store data (rs2)
lsu_data_o  out  32  load result, valid in DONE
lsu_stall_req_o  out  1  core must hold pipeline
lsu_fault_o  out  1  one-cycle fault pulse
lsu_fault_cause_o  out  2  01 misaligned, 10 bad size, 11 bus timeout
data_req_o  out  1  memory request
data_we_o  out  1  memory write
data_be_o  out  4  byte enables
data_addr_o  out  32  word address, bits [1:0]=0
data_wdata_o  out  32  lane-replicated store data
data_rdata_i  in  32  memory read data
data_ack_i  in  1  access complete, rdata valid same cycle

Behaviour:
- Reset: all registered outputs 0. State IDLE, timeout counter 0. lsu_stall_req_o=0.
- States: IDLE, WAIT, DONE.
- IDLE, lsu_req_i=1, request legal:
  - Register data_req_o=1, data_we_o, data_be_o, data_addr_o={addr[31:2],2'b00}, data_wdata_o.
  - Go to WAIT. Counter cleared.
- Legality checks:
  - Bad size: size in {3,6,7}, or store with size 4/5 -> cause 10.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0 -> cause 01.
  - Bad size takes priority over misaligned.
  - On fault: lsu_fault_o=1 for exactly one cycle (registered, next cycle), no bus access, stay IDLE.
- WAIT:
  - data_req_o and all bus outputs held stable.
  - data_ack_i=1: data_req_o->0. On a load, register the extended result into lsu_data_o. Go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with no ack: data_req_o->0, lsu_fault_o pulse with cause 11, go to DONE.
  - Ack and timeout in the same cycle: ack wins, no fault.
- DONE: one cycle. lsu_req_i is ignored (it belongs to the completed instruction). Return to IDLE.
- lsu_stall_req_o (combinational):
  - 1 in WAIT.
  - 1 in IDLE when lsu_req_i=1 and the request is legal.
  - 0 in DONE, 0 for faulting requests.
- Minimum latency: request seen cycle N, data_req_o high N+1, ack N+1, DONE N+2. Stall is high N..N+1 and low at N+2.
- Store lane rules, with off=addr[1:0]:
  - B: be=0001<<off, wdata={4{d[7:0]}}.
  - H: be=0011<<off, wdata={2{d[15:0]}}.
  - W: be=1111, wdata=d.
- Load extract:
  - B/BU: byte rdata[8*off+:8].
  - H/HU: half rdata[8*off+:16].
  - B and H sign-extend; BU and HU zero-extend; W passes through.
- data_ack_i outside WAIT is ignored.
- lsu_data_o holds its value until the next completed load. Stores leave it unchanged.
- rst_i mid-WAIT: data_req_o=0 next cycle, no fault, state IDLE.

Test Plan:
- LW addr 0x100, memory acks after 3 cycles with rdata 0xDEADBEEF -> data_addr_o=0x100, be=1111, stall 4 cycles, lsu_data_o=0xDEADBEEF in DONE.
- LB addr 0x203, rdata 0x80112233 -> be 1000 on request; lsu_data_o=0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH addr 0x302, data 0x0000ABCD, immediate ack -> data_we_o=1, be=1100, wdata=0xABCDABCD, addr=0x300; lsu_data_o unchanged.
- LW addr 0x101 -> no data_req_o, lsu_fault_o one cycle with cause 01, no stall. Store with size 4 -> cause 10.
- TIMEOUT=4, never ack -> data_req_o high 4 cycles then drops, fault cause 11. Ack on exactly the 4th cycle -> no fault.
- rst_i asserted in the 2nd WAIT cycle -> next cycle data_req_o=0, stall=0, all outputs 0; a following LW completes normally.
